// File: rtl/pmf_reservation_station_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pmf_reservation_station_pkg
// Description : Shared labels, ALU op codes and depth for the add/sub/and/or
//               reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
package pmf_reservation_station_pkg;

    typedef logic [3:0] label_t;

    // Label 0 marks an operand whose value is already valid
    localparam label_t     c_LABEL_NONE   = 4'd0;

    localparam logic [1:0] c_ALU_ADD      = 2'd0;
    localparam logic [1:0] c_ALU_SUB      = 2'd1;
    localparam logic [1:0] c_ALU_AND      = 2'd2;
    localparam logic [1:0] c_ALU_OR       = 2'd3;

    localparam int         c_RS_DEPTH_PMF = 3;

    function automatic logic cdb_hit(input label_t q, input logic cdb_en,
                                     input label_t cdb_label);
        return cdb_en && (q != c_LABEL_NONE) && (q == cdb_label);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmf_reservation_station_rs_entry.sv
`default_nettype none
// ============================================================================
// Module      : pmf_reservation_station_rs_entry
// Description : One reservation-station slot: busy/op/V/Q state, issue write
//               with same-cycle CDB bypass, CDB snoop and ready flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pmf_reservation_station_rs_entry
    import pmf_reservation_station_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              i_flush,
    input  logic              i_issue_we,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  label_t            i_label1,
    input  label_t            i_label2,
    input  logic              i_cdb_en,
    input  label_t            i_cdb_label,
    input  logic [DATA_W-1:0] i_cdb_data,
    input  logic              i_dispatch_clr,
    output logic              o_busy,
    output logic              o_ready,
    output logic [1:0]        o_op,
    output logic [DATA_W-1:0] o_v1,
    output logic [DATA_W-1:0] o_v2
);

    logic              r_busy;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_v1;
    logic [DATA_W-1:0] r_v2;
    label_t            r_q1;
    label_t            r_q2;

    always_ff @(posedge clk) begin
        if (RST || i_flush) begin
            r_busy <= 1'b0;
            r_op   <= c_ALU_ADD;
            r_v1   <= '0;
            r_v2   <= '0;
            r_q1   <= c_LABEL_NONE;
            r_q2   <= c_LABEL_NONE;
        end else if (i_issue_we) begin
            // Issue only targets a free slot, so it never collides with snoop/dispatch
            r_busy <= 1'b1;
            r_op   <= i_op;
            if (cdb_hit(i_label1, i_cdb_en, i_cdb_label)) begin
                r_v1 <= i_cdb_data;
                r_q1 <= c_LABEL_NONE;
            end else begin
                r_v1 <= i_data1;
                r_q1 <= i_label1;
            end
            if (cdb_hit(i_label2, i_cdb_en, i_cdb_label)) begin
                r_v2 <= i_cdb_data;
                r_q2 <= c_LABEL_NONE;
            end else begin
                r_v2 <= i_data2;
                r_q2 <= i_label2;
            end
        end else begin
            if (i_dispatch_clr) begin
                r_busy <= 1'b0;
            end
            if (r_busy && cdb_hit(r_q1, i_cdb_en, i_cdb_label)) begin
                r_v1 <= i_cdb_data;
                r_q1 <= c_LABEL_NONE;
            end
            if (r_busy && cdb_hit(r_q2, i_cdb_en, i_cdb_label)) begin
                r_v2 <= i_cdb_data;
                r_q2 <= c_LABEL_NONE;
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_ready = r_busy && (r_q1 == c_LABEL_NONE) && (r_q2 == c_LABEL_NONE);
    assign o_op    = r_op;
    assign o_v1    = r_v1;
    assign o_v2    = r_v2;

endmodule
`default_nettype wire

// File: rtl/pmf_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : pmf_reservation_station
// Description : Reservation station feeding the plus/minus ALU; allocates the
//               lowest free slot and dispatches the lowest ready slot.
// Revision    : 1.0 - initial release
// ============================================================================
module pmf_reservation_station
    import pmf_reservation_station_pkg::*;
#(
    parameter int     DEPTH      = c_RS_DEPTH_PMF,
    parameter label_t LABEL_BASE = 4'd1,
    parameter int     DATA_W     = 32
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              flush,
    input  logic              issueEN,
    input  logic [1:0]        issueOp,
    input  logic [DATA_W-1:0] issueData1,
    input  logic [DATA_W-1:0] issueData2,
    input  logic [3:0]        issueLabel1,
    input  logic [3:0]        issueLabel2,
    output logic              full,
    output logic [3:0]        allocLabel,
    input  logic              cdbEN,
    input  logic [3:0]        cdbLabel,
    input  logic [DATA_W-1:0] cdbData,
    input  logic              aluAvailable,
    output logic              dispatchWEN,
    output logic [1:0]        dispatchOp,
    output logic [DATA_W-1:0] dispatchData1,
    output logic [DATA_W-1:0] dispatchData2,
    output logic [3:0]        dispatchLabel
);

    logic [DEPTH-1:0]  w_busy;
    logic [DEPTH-1:0]  w_ready;
    logic [1:0]        w_op [DEPTH];
    logic [DATA_W-1:0] w_v1 [DEPTH];
    logic [DATA_W-1:0] w_v2 [DEPTH];
    logic [2:0]        w_alloc_idx;
    logic [2:0]        w_sel_idx;
    logic              w_issue_fire;

    // Descending scan leaves the lowest matching index in the result
    always_comb begin
        w_alloc_idx = '0;
        w_sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_busy[i]) begin
                w_alloc_idx = 3'(i);
            end
            if (w_ready[i]) begin
                w_sel_idx = 3'(i);
            end
        end
    end

    assign full         = &w_busy;
    assign allocLabel   = LABEL_BASE + {1'b0, w_alloc_idx};
    assign w_issue_fire = issueEN && !full;
    // A reset/flush cycle discards state, so nothing may leave in that cycle
    assign dispatchWEN  = (|w_ready) && aluAvailable && !RST && !flush;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            pmf_reservation_station_rs_entry #(
                .DATA_W (DATA_W)
            ) u_entry (
                .clk            (clk),
                .RST            (RST),
                .i_flush        (flush),
                .i_issue_we     (w_issue_fire && (w_alloc_idx == 3'(gi))),
                .i_op           (issueOp),
                .i_data1        (issueData1),
                .i_data2        (issueData2),
                .i_label1       (issueLabel1),
                .i_label2       (issueLabel2),
                .i_cdb_en       (cdbEN),
                .i_cdb_label    (cdbLabel),
                .i_cdb_data     (cdbData),
                .i_dispatch_clr (dispatchWEN && (w_sel_idx == 3'(gi))),
                .o_busy         (w_busy[gi]),
                .o_ready        (w_ready[gi]),
                .o_op           (w_op[gi]),
                .o_v1           (w_v1[gi]),
                .o_v2           (w_v2[gi])
            );
        end
    endgenerate

    always_comb begin
        dispatchOp    = '0;
        dispatchData1 = '0;
        dispatchData2 = '0;
        dispatchLabel = c_LABEL_NONE;
        for (int i = 0; i < DEPTH; i++) begin
            if (dispatchWEN && (w_sel_idx == 3'(i))) begin
                dispatchOp    = w_op[i];
                dispatchData1 = w_v1[i];
                dispatchData2 = w_v2[i];
                dispatchLabel = LABEL_BASE + 4'(i);
            end
        end
    end

endmodule
`default_nettype wire
